// File: rtl/iir_coeff_ctrl.sv
// iir_coeff_ctrl: coefficient shadow/commit controller for a two-stage
// cascaded biquad IIR filter. Writes land in a shadow bank. All ten live
// coefficients switch together on the first sample boundary after the
// update has been closed with cfg_last.
// Optional build macro: IIR_CFG_FLUSH_EN. When it is defined, filter_rst
// pulses with commit_done so the biquad state is flushed at the switch.
// When it is undefined, filter_rst is tied low.
//
// state | meaning
// IDLE  | no update open, live bank equals shadow bank
// LOAD  | update open, accepting shadow writes
// PEND  | update closed, waiting for sample_strobe to commit
module iir_coeff_ctrl #(
    parameter int COEFF_WIDTH = 16,
    parameter int FRAC_BITS   = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [3:0]             cfg_addr,
    input  logic [COEFF_WIDTH-1:0] cfg_data,
    input  logic                   cfg_last,
    input  logic                   cfg_abort,
    input  logic                   sample_strobe,
    output logic [COEFF_WIDTH-1:0] b0_1,
    output logic [COEFF_WIDTH-1:0] b1_1,
    output logic [COEFF_WIDTH-1:0] b2_1,
    output logic [COEFF_WIDTH-1:0] a1_1,
    output logic [COEFF_WIDTH-1:0] a2_1,
    output logic [COEFF_WIDTH-1:0] b0_2,
    output logic [COEFF_WIDTH-1:0] b1_2,
    output logic [COEFF_WIDTH-1:0] b2_2,
    output logic [COEFF_WIDTH-1:0] a1_2,
    output logic [COEFF_WIDTH-1:0] a2_2,
    output logic                   busy,
    output logic                   commit_done,
    output logic                   cfg_err,
    output logic                   filter_rst
);

    localparam int NCOEF = 10;
    localparam logic [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(1) << FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [COEFF_WIDTH-1:0] live_q   [NCOEF];
    logic [COEFF_WIDTH-1:0] live_d   [NCOEF];
    logic [COEFF_WIDTH-1:0] shadow_q [NCOEF];
    logic [COEFF_WIDTH-1:0] shadow_d [NCOEF];
    logic                   commit_done_q, commit_done_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   xfer;
`ifdef IIR_CFG_FLUSH_EN
    logic                   filter_rst_q, filter_rst_d;
`endif

    assign cfg_ready = (state_q != PEND);
    assign xfer      = cfg_valid && cfg_ready;

    // Next-state, shadow write, commit and abort decisions.
    always_comb begin
        state_d       = state_q;
        live_d        = live_q;
        shadow_d      = shadow_q;
        commit_done_d = 1'b0;
        cfg_err_d     = cfg_err_q;
`ifdef IIR_CFG_FLUSH_EN
        filter_rst_d  = 1'b0;
`endif
        if (cfg_abort && (state_q != IDLE)) begin
            // Abort beats both a strobe and a concurrent write; the shadow
            // falls back to the live set so later partial updates start clean.
            state_d  = IDLE;
            shadow_d = live_q;
        end else if (state_q == PEND) begin
            if (sample_strobe) begin
                live_d        = shadow_q;
                commit_done_d = 1'b1;
`ifdef IIR_CFG_FLUSH_EN
                filter_rst_d  = 1'b1;
`endif
                state_d       = IDLE;
            end
        end else if (xfer) begin
            if (cfg_addr < 4'(NCOEF)) begin
                for (int i = 0; i < NCOEF; i++) begin
                    if (cfg_addr == i[3:0]) begin
                        shadow_d[i] = cfg_data;
                    end
                end
            end else begin
                cfg_err_d = 1'b1;
            end
            state_d = cfg_last ? PEND : LOAD;
        end
    end

    // State and bank registers; reset restores the pass-through set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            commit_done_q <= 1'b0;
            cfg_err_q     <= 1'b0;
`ifdef IIR_CFG_FLUSH_EN
            filter_rst_q  <= 1'b0;
`endif
            for (int i = 0; i < NCOEF; i++) begin
                live_q[i]   <= (i == 0 || i == 5) ? UNITY : '0;
                shadow_q[i] <= (i == 0 || i == 5) ? UNITY : '0;
            end
        end else begin
            state_q       <= state_d;
            commit_done_q <= commit_done_d;
            cfg_err_q     <= cfg_err_d;
`ifdef IIR_CFG_FLUSH_EN
            filter_rst_q  <= filter_rst_d;
`endif
            live_q        <= live_d;
            shadow_q      <= shadow_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign commit_done = commit_done_q;
    assign cfg_err     = cfg_err_q;
`ifdef IIR_CFG_FLUSH_EN
    assign filter_rst  = filter_rst_q;
`else
    assign filter_rst  = 1'b0;
`endif

    assign b0_1 = live_q[0];
    assign b1_1 = live_q[1];
    assign b2_1 = live_q[2];
    assign a1_1 = live_q[3];
    assign a2_1 = live_q[4];
    assign b0_2 = live_q[5];
    assign b1_2 = live_q[6];
    assign b2_2 = live_q[7];
    assign a1_2 = live_q[8];
    assign a2_2 = live_q[9];

endmodule
